// File: rtl/led_nios2_qsys_mult_pkg.sv
// Shared constants and types for the multiplier arbiter.
// The rsp entry carries the issuing requester index alongside the low product.
package led_nios2_qsys_mult_pkg;

  localparam int MUL_W           = 32;
  localparam int MUL_LATENCY_DEF = 1;
  localparam int RSP_IDW_MAX     = 2;  // enough for up to four requesters

  // Requester index width; one bit minimum so a single requester still has an id.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [RSP_IDW_MAX-1:0] id;
    logic [MUL_W-1:0]       data;
  } rsp_entry_t;

endpackage

// File: rtl/led_nios2_qsys_mult_arbiter_if.sv
// Requester/response handshake bundle. The master side is the requesters plus
// the response consumer; the slave side is the arbiter.
interface led_nios2_qsys_mult_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = led_nios2_qsys_mult_pkg::idw(NUM_REQ)
);
  import led_nios2_qsys_mult_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [MUL_W*NUM_REQ-1:0] req_src1;
  logic [MUL_W*NUM_REQ-1:0] req_src2;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [MUL_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/led_nios2_qsys_mult_rsp_fifo.sv
// Synchronous response FIFO. Storage is plain flops without reset; only the
// pointers and the count are cleared, so a reset drops all queued entries.
// The head is read straight from storage and forced to zero when empty.
// A push-into-full check is compiled in unless SYNTHESIS is defined.
module led_nios2_qsys_mult_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;
  logic             full;

  assign valid  = (count_q != '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign do_pop = pop & valid;
  assign head   = valid ? mem_q[rd_ptr_q] : '0;

  // Pointer and occupancy next state; push and pop together leave count unchanged.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("response fifo pushed while full");
`endif

endmodule

// File: rtl/led_nios2_qsys_mult_arbiter.sv
// Shares one low-product multiplier cell among NUM_REQ requesters.
// Per-cycle arbitration, operand steering, an issue shift register that tags
// in-flight products with their requester id, and a credit counter that only
// grants while in-flight + queued results fit in the response FIFO.
// Define LED_NIOS2_QSYS_MULT_ARB_RR_EN for round-robin; otherwise lowest index wins.
module led_nios2_qsys_mult_arbiter
  import led_nios2_qsys_mult_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_nios2_qsys_mult_arbiter_if.slave bus,
  output logic [MUL_W-1:0]      A_mul_src1,
  output logic [MUL_W-1:0]      A_mul_src2,
  input  logic [MUL_W-1:0]      A_mul_cell_result,
  output logic                  idle
);

  localparam int IDW  = idw(NUM_REQ);
  localparam int OCCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCCW-1:0] CREDITS = OCCW'(FIFO_DEPTH);

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   base_idx;
  logic [IDW-1:0]   cand;
  logic [OCCW-1:0]  occ_q, occ_d;
  logic             pipe_vld_q [MUL_LATENCY];
  logic             pipe_vld_d [MUL_LATENCY];
  logic [IDW-1:0]   pipe_id_q  [MUL_LATENCY];
  logic [IDW-1:0]   pipe_id_d  [MUL_LATENCY];
  logic             pop;
  logic             fifo_valid;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;

  // Search position k steps after base, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int c;
    c = int'(base) + k;
    if (c >= NUM_REQ) c = c - NUM_REQ;
    return IDW'(c);
  endfunction

`ifdef LED_NIOS2_QSYS_MULT_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  assign base_idx = ptr_q;

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  assign base_idx = '0;
`endif

  // Pick the first valid requester at or after base; only while a credit is free.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (occ_q < CREDITS) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = wrap_idx(base_idx, k);
        if (bus.req_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // One-hot ready and operand steering to the cell; zeros when nothing is granted.
  always_comb begin
    bus.req_ready = '0;
    A_mul_src1    = '0;
    A_mul_src2    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_vld && gnt_idx == IDW'(k)) begin
        bus.req_ready[k] = 1'b1;
        A_mul_src1       = bus.req_src1[k*MUL_W +: MUL_W];
        A_mul_src2       = bus.req_src2[k*MUL_W +: MUL_W];
      end
    end
  end

  // Issue tracking and credits: the tail of the shift register lines up with the cell result.
  always_comb begin
    pipe_vld_d[0] = gnt_vld;
    pipe_id_d[0]  = gnt_idx;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
    case ({gnt_vld, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Issue shift register and occupancy counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_id_q[i]  <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_id_q[i]  <= pipe_id_d[i];
      end
      occ_q <= occ_d;
    end
  end

  // Result capture into the FIFO and response outputs.
  always_comb begin
    push_entry.id   = RSP_IDW_MAX'(pipe_id_q[MUL_LATENCY-1]);
    push_entry.data = A_mul_cell_result;
  end

  assign pop           = fifo_valid & bus.rsp_ready;
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_id    = IDW'(head_entry.id);
  assign bus.rsp_data  = head_entry.data;
  assign idle          = (occ_q == '0);

  led_nios2_qsys_mult_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (pipe_vld_q[MUL_LATENCY-1]),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (head_entry)
  );

endmodule
